seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
// Programmable serial bit-pattern detector; generalises the fixed "101" Moore
// detector to any pattern of 1..MAX_LEN bits, with overlap/non-overlap mode,
// input qualifier and a saturating match counter. Sits on a serial bit stream
// (frame-sync / preamble hunt) and flags each completed pattern one cycle later.
// PARAMETERS
// MAX_LEN      8       longest supported pattern, bits (>=2)
// CNT_W        16      width of match counter
// DEF_PATTERN  'b101   pattern loaded at reset (right-aligned)
// DEF_LEN      3       pattern length loaded at reset
// DEF_OVERLAP  1       overlap mode loaded at reset
// PORTS
// clk          in   1            clock, all state on posedge
// rst_n        in   1            asynchronous reset, active low
// cfg_load     in   1            latch cfg_pattern/cfg_len/cfg_overlap this cycle
// cfg_pattern  in   MAX_LEN      pattern, right-aligned; bit[len-1] received first
// cfg_len      in   LEN_W        pattern length; LEN_W=$clog2(MAX_LEN+1)
// cfg_overlap  in   1            1: overlapping matches allowed; 0: restart after match
// en           in   1            detector enable; 0 freezes history and counters
// x_valid      in   1            x carries a bit this cycle
// x            in   1            serial data bit
// match        out  1            registered pulse: pattern completed by previous accepted bit
// match_cnt    out  CNT_W        number of matches, saturates at all-ones
// cnt_clr      in   1            synchronous clear of match_cnt
// BEHAVIOUR
// - Reset (async): hist=0, fill=0, match=0, match_cnt=0; pattern/len/overlap=DEF_*.
// - Accepted bit: en && x_valid && !cfg_load. hist <= {hist[MAX_LEN-2:0],x};
//   fill <= min(fill+1, len). fill = count of valid history bits (state register).
// - hit = accepted && (fill+1 >= len) && next_hist[len-1:0]==pattern[len-1:0].
// - match <= hit every cycle (1-cycle pulse per hit, latency 1 clk after the bit).
// - On hit: overlap=1 -> fill stays saturated (next bit may complete another hit);
//   overlap=0 -> fill <= 0 (no bit of this match is reused).
// - Not accepted: hist/fill hold, match <= 0.
// - cfg_load: latches config, fill <= 0, match <= 0; any x_valid that cycle dropped.
//   cfg_len > MAX_LEN latched as MAX_LEN; cfg_len == 0 latched as 0 = no match ever.
//   Pattern bits above len ignored.
// - match_cnt: +1 on same edge as match rises; holds at 2^CNT_W-1; cnt_clr wins
//   over coincident hit (result 0, match still pulses). cfg_load does not clear it.
// - en=0: inputs ignored; match <= 0; cnt_clr still honoured.
// - rst_n low mid-stream: everything returns to reset values immediately.
// STRUCTURE
// - seq_det_pkg: LEN_W function/const, DEF_* constants, clamp_len() function.
// - Sub-module sat_counter #(W) (clk, rst_n, clr, inc, q): saturating counter,
//   clr priority; instantiated once for match_cnt.
// - Top: config regs, hist shift reg, fill counter, compare/mask logic, match reg.
// TESTING
// 1 Defaults, stream 1,0,1,0,1 -> match 1 clk after bits 3 and 5; match_cnt=2.
// 2 cfg 4'b1011 len4 overlap=0, stream 1011011 -> one match after bit 4 only
//   (bits 5-7 "011" incomplete); overlap=1 same stream -> matches after 4 and 7.
// 3 x_valid gaps/en=0 inside 1,0,1 -> match still after third accepted bit only.
// 4 CNT_W=2, 5 matches -> match_cnt stays 3; cnt_clr coincident with hit -> 0.
// 5 cfg_load with x_valid after 2 bits of "101" -> bit dropped, no match
//   until 3 fresh bits; cfg_len=0 -> no match on any stream; cfg_len=15 -> MAX_LEN.
// 6 rst_n pulse after 2 bits of "101" -> outputs 0, next "1" alone gives no match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Reset-time pattern defaults and length clamping live here.
package seq_det_pkg;

    localparam int        DEF_MAX_LEN = 8;
    localparam int        DEF_CNT_W   = 16;
    localparam int        DEF_PAT     = 'b101;
    localparam int        DEF_LEN_C   = 3;
    localparam bit        DEF_OVL     = 1'b1;

    // Bits needed to hold a length of 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Lengths beyond the supported maximum are treated as the maximum.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with a clear that beats a coincident increment.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Clear first, then count unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control,
// input qualifier and saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEF_PATTERN = DEF_PAT,
    parameter int DEF_LEN     = DEF_LEN_C,
    parameter bit DEF_OVERLAP = DEF_OVL,
    localparam int LEN_W      = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               en,
    input  logic               x_valid,
    input  logic               x,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    input  logic               cnt_clr
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    logic               accepted;
    logic [MAX_LEN-1:0] next_hist;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic               hit;
    logic [LEN_W-1:0]   fill_nxt;
    logic [LEN_W-1:0]   len_d;

    assign accepted  = en && x_valid && !cfg_load;
    assign next_hist = {hist_q[MAX_LEN-2:0], x};
    assign fill_inc  = {1'b0, fill_q} + (LEN_W+1)'(1);
    assign len_d     = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

    // Compare mask covers only the low len bits of history and pattern.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // A hit needs a non-empty pattern, enough fresh bits and equality.
    always_comb begin
        hit = accepted && (len_q != '0)
            && (fill_inc >= {1'b0, len_q})
            && (((next_hist ^ pat_q) & mask) == '0);
        if (hit && !ovl_q) begin
            fill_nxt = '0;
        end else if (fill_inc >= {1'b0, len_q}) begin
            fill_nxt = len_q;
        end else begin
            fill_nxt = fill_inc[LEN_W-1:0];
        end
    end

    // Config registers, history, fill level and the match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= MAX_LEN'(DEF_PATTERN);
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            match  <= 1'b0;
        end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            len_q  <= len_d;
            ovl_q  <= cfg_overlap;
            fill_q <= '0;
            match  <= 1'b0;
        end else if (accepted) begin
            hist_q <= next_hist;
            fill_q <= fill_nxt;
            match  <= hit;
        end else begin
            match  <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (hit),
        .q     (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_seq_detector_prog;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       cfg_load = 0;
    logic [7:0] cfg_pattern = 0;
    logic [3:0] cfg_len = 0;
    logic       cfg_overlap = 0;
    logic       en = 0;
    logic       x_valid = 0;
    logic       x = 0;
    logic       cnt_clr = 0;
    logic       match, match_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_detector_prog dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .en(en), .x_valid(x_valid),
        .x(x), .match(match), .match_cnt(cnt), .cnt_clr(cnt_clr)
    );

    seq_detector_prog #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .en(en), .x_valid(x_valid),
        .x(x), .match(match_s), .match_cnt(cnt_s), .cnt_clr(cnt_clr)
    );

    // Reference model: queue of usable received bits.
    bit       q[$];
    int       m_len = 3;
    bit [7:0] m_pat = 8'b101;
    bit       m_ovl = 1;
    bit       m_match = 0;
    int       m_cnt = 0;
    int       m_cnt_s = 0;

    always @(posedge clk or negedge rst_n) begin
        bit hit;
        if (!rst_n) begin
            q.delete();
            m_len = 3; m_pat = 8'b101; m_ovl = 1;
            m_match = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            hit = 0;
            if (cfg_load) begin
                m_pat = cfg_pattern;
                m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
                m_ovl = cfg_overlap;
                q.delete();
            end else if (en && x_valid) begin
                q.push_back(x);
                if (q.size() > 8) void'(q.pop_front());
                if (m_len > 0 && q.size() >= m_len) begin
                    hit = 1;
                    for (int k = 0; k < m_len; k++)
                        if (q[q.size() - m_len + k] != m_pat[m_len-1-k])
                            hit = 0;
                end
                if (hit && !m_ovl) q.delete();
            end
            m_match = hit;
            if (cnt_clr) begin
                m_cnt = 0; m_cnt_s = 0;
            end else if (hit) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("m_match", int'(match), int'(m_match));
        check("m_match_s", int'(match_s), int'(m_match));
        check("m_cnt", int'(cnt), m_cnt);
        check("m_cnt_s", int'(cnt_s), m_cnt_s);
    end

    // Send one accepted bit and check the literal match expectation.
    task automatic send(input bit b, input bit exp_m, input bit clr = 0);
        x_valid = 1; x = b; cnt_clr = clr;
        @(posedge clk); #1;
        x_valid = 0; cnt_clr = 0;
        check("lit_match", int'(match), int'(exp_m));
    endtask

    task automatic gap(input bit en_v, input bit xv);
        en = en_v; x_valid = xv; x = 1;
        @(posedge clk); #1;
        en = 1; x_valid = 0;
        check("lit_gap", int'(match), 0);
    endtask

    task automatic cfg(input bit [7:0] p, input bit [3:0] l,
                       input bit o, input bit xv = 0);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        cfg_load = 1; x_valid = xv; x = 1;
        @(posedge clk); #1;
        cfg_load = 0; x_valid = 0;
        check("lit_cfg", int'(match), 0);
    endtask

    task automatic clr();
        cnt_clr = 1;
        @(posedge clk); #1;
        cnt_clr = 0;
        check("lit_clr", int'(cnt), 0);
    endtask

    bit [7:0] pv;

    initial begin
        #12;
        check("rst_match", int'(match), 0);
        check("rst_cnt", int'(cnt), 0);
        rst_n = 1; en = 1;
        @(posedge clk); #1;

        // Defaults: 101 overlapping
        send(1,0); send(0,0); send(1,1); send(0,0); send(1,1);
        check("t1_cnt", int'(cnt), 2);

        // 1011 non-overlap vs overlap
        clr();
        cfg(8'b1011, 4, 0);
        send(1,0); send(0,0); send(1,0); send(1,1);
        send(0,0); send(1,0); send(1,0);
        check("t2_cnt_no", int'(cnt), 1);
        clr();
        cfg(8'b1011, 4, 1);
        send(1,0); send(0,0); send(1,0); send(1,1);
        send(0,0); send(1,0); send(1,1);
        check("t2_cnt_ov", int'(cnt), 2);

        // Gaps and en=0 inside 101
        cfg(8'b101, 3, 1);
        clr();
        send(1,0); gap(1,0); send(0,0); gap(0,1); send(1,1);
        check("t3_cnt", int'(cnt), 1);

        // Saturation and clear-vs-hit
        clr();
        send(1,0);
        for (int i = 0; i < 5; i++) begin
            send(0,0); send(1,1);
        end
        check("t4_sat", int'(cnt_s), 3);
        check("t4_big", int'(cnt), 5);
        send(0,0); send(1,1,1);
        check("t4_clr_s", int'(cnt_s), 0);
        check("t4_clr", int'(cnt), 0);

        // cfg_load drops a coincident bit and restarts history
        send(1,0); send(0,0);
        cfg(8'b101, 3, 1, 1);
        send(1,0); send(0,0); send(1,1);
        cfg(8'h00, 0, 1);
        for (int i = 0; i < 20; i++) send(1'($urandom), 0);
        cfg(8'hA5, 15, 1);
        pv = 8'hA5;
        for (int i = 7; i >= 0; i--) send(pv[i], i == 0);

        // Reset mid-stream
        cfg(8'b101, 3, 1);
        send(1,0); send(0,0);
        #2 rst_n = 0;
        #1;
        check("t6_match", int'(match), 0);
        check("t6_cnt", int'(cnt), 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
        send(1,0); send(0,0); send(1,1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            x_valid = ($urandom_range(0, 4) != 0);
            x = 1'($urandom);
            cnt_clr = ($urandom_range(0, 49) == 0);
            cfg_load = en && ($urandom_range(0, 59) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len = 4'($urandom_range(0, 5) == 0 ?
                          $urandom_range(0, 15) : $urandom_range(1, 4));
            cfg_overlap = 1'($urandom);
            @(posedge clk); #1;
        end
        en = 1; x_valid = 0; cfg_load = 0; cnt_clr = 0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
